uart_rx_param: RTL

Parametrised UART receiver, the successor to the fixed 8-bit `receiver`. It adds configurable data width, parity mode, stop-bit count and bit period. It uses 3-sample majority voting at mid-bit, rejects false start bits, and reports parity and framing errors. A held output word uses a valid/ready handshake with overrun detection. It sits between the external `rx` pin and the byte-consuming logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sampler.sv | 46 ++++
 rtl/uart_rx_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, receiver FSM states, majority helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-flop synchroniser plus 3-tap mid-bit capture and majority vote.
// Latency: 2 cycles rx -> rx_s; bit_val is valid combinationally at cnt = H+1.
// Backpressure: none, free-running.
// Ports: clk1, reset (sync, active-high), rx (async line), cnt (bit-phase counter
//        from the FSM) -> rx_s (synchronised line), bit_val (voted bit value).
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                            clk1,
    input  logic                            reset,
    input  logic                            rx,
    input  logic [$clog2(CLKS_PER_BIT)-1:0] cnt,
    output logic                            rx_s,
    output logic                            bit_val
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_TAP0 = CW'(H - 1);
    localparam logic [CW-1:0] CNT_TAP1 = CW'(H);

    logic rx_m;
    logic tap0;
    logic tap1;

    // Idle-high reset values keep a reset from looking like a start edge.
    always_ff @(posedge clk1) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            tap0 <= 1'b1;
            tap1 <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            if (cnt == CNT_TAP0) tap0 <= rx_s;
            if (cnt == CNT_TAP1) tap1 <= rx_s;
        end
    end

    // Third sample is the live rx_s at cnt = H+1, so the vote lands that cycle.
    assign bit_val = maj3(tap0, tap1, rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit majority voting, parity/framing checks.
// Latency: valid_frame rises one cycle after the last stop-bit decision.
// Backpressure: one-word holding register with valid/ready; a frame completing
//               while the register is full and unread is dropped and overrun pulses.
// Ports: clk1, reset (sync, active-high), rx, rd_ready -> valid_frame, d_out,
//        parity_err, frame_err, overrun, busy.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk1,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd_ready,
    output logic                 valid_frame,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int IW = 4;
    localparam logic [CW-1:0] CNT_DEC   = CW'(H + 1);
    localparam logic [CW-1:0] CNT_END   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    uart_rx_state_t       state;
    uart_rx_state_t       state_n;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 frm_bad;
    logic                 rx_s;
    logic                 bit_val;
    logic                 decide;
    logic                 bit_end;
    logic                 done;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk1    (clk1),
        .reset   (reset),
        .rx      (rx),
        .cnt     (cnt),
        .rx_s    (rx_s),
        .bit_val (bit_val)
    );

    assign decide = (cnt == CNT_DEC);
    assign bit_end = (cnt == CNT_END);
    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk1) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!rx_s) state_n = RX_START;
            end
            RX_START: begin
                if (decide && bit_val) state_n = RX_IDLE;   // false start
                else if (bit_end)      state_n = RX_DATA;
            end
            RX_DATA: begin
                if (bit_end && bit_idx == LAST_DATA)
                    state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (bit_end) state_n = RX_STOP;
            end
            RX_STOP: begin
                // Leave mid-bit so a back-to-back start edge is not missed.
                if (decide && bit_idx == LAST_STOP) begin
                    state_n = RX_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    // Per-bit phase counter and bit index both restart on every state change.
    always_ff @(posedge clk1) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
            frm_bad <= 1'b0;
        end else begin
            cnt     <= (state == RX_IDLE || state_n != state || bit_end) ? '0 : cnt + 1'b1;
            bit_idx <= (state_n != state) ? '0 : (bit_end ? bit_idx + 1'b1 : bit_idx);
            if (state == RX_IDLE) begin
                par_bad <= 1'b0;
                frm_bad <= 1'b0;
            end
            if (state == RX_DATA && decide)
                shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (state == RX_PARITY && decide)
                par_bad <= ((^shreg) ^ bit_val) != (PARITY == PAR_ODD);
            if (state == RX_STOP && decide && !bit_val)
                frm_bad <= 1'b1;
        end
    end

    // The final stop bit is still in bit_val on the done cycle, so fold it in here.
    always_ff @(posedge clk1) begin
        if (reset) begin
            valid_frame <= 1'b0;
            d_out       <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid_frame || rd_ready) begin
                    valid_frame <= 1'b1;
                    d_out       <= shreg;
                    parity_err  <= par_bad;
                    frame_err   <= frm_bad | ~bit_val;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_frame && rd_ready) begin
                valid_frame <= 1'b0;
            end
        end
    end

endmodule
